// File: rtl/rs485_pkg.sv
// Shared RS485 definitions: receiver FSM state encoding and line constants.
package rs485_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    BREAK = 3'd4
  } rx_state_t;

  localparam int   FRAME_BITS = 10;
  localparam logic LINE_IDLE  = 1'b1;

endpackage

// File: rtl/rs485_rx_sync.sv
// Two-flop synchroniser for an asynchronous serial line; reset value is the idle level.
module rs485_rx_sync
  import rs485_pkg::*;
#(
  parameter logic RST_VAL = LINE_IDLE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rs485_uart_rx.sv
// 8N1 (5..8 data bits) UART receiver: start detect, mid-bit sampling, deframing, framing-error flag.
// Outputs byte_valid/frame_err are registered one-cycle pulses; there is no backpressure (no ready).
module rs485_uart_rx
  import rs485_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_en,
  input  logic                 Rx,
  output logic [DATA_BITS-1:0] byte_out,
  output logic                 byte_valid,
  output logic                 frame_err,
  output logic                 busy,
  output rx_state_t            state_dbg
);

  localparam int HALF  = (CLKS_PER_BIT - 1) / 2;
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, idx_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [DATA_BITS-1:0] byte_nxt;
  logic                 valid_nxt, err_nxt;

  rs485_rx_sync #(.RST_VAL(LINE_IDLE)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (Rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shreg      <= '0;
      byte_out   <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      bit_idx    <= idx_nxt;
      shreg      <= shreg_nxt;
      byte_out   <= byte_nxt;
      byte_valid <= valid_nxt;
      frame_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = bit_idx;
    shreg_nxt = shreg;
    byte_nxt  = byte_out;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    if (!rx_en) begin
      // Abort any frame in progress; byte_out is left untouched.
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (!rx_s) begin
            // With no half-bit to wait out, this sample is the start confirmation.
            if (HALF == 0) begin
              cnt_nxt   = CNT_FULL;
              idx_nxt   = '0;
              state_nxt = DATA;
            end else begin
              cnt_nxt   = CNT_HALF;
              state_nxt = START;
            end
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
          end else if (!rx_s) begin
            cnt_nxt   = CNT_FULL;
            idx_nxt   = '0;
            state_nxt = DATA;
          end else begin
            state_nxt = IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
          end else begin
            shreg_nxt = {rx_s, shreg[DATA_BITS-1:1]};
            cnt_nxt   = CNT_FULL;
            if (bit_idx == IDX_LAST) state_nxt = STOP;
            else                     idx_nxt   = bit_idx + IDX_W'(1);
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
          end else if (rx_s) begin
            byte_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = BREAK;
          end
        end
        BREAK: begin
          if (rx_s) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
